// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
package uart_pkg;

    // Default timing matches one full output period of the divide-by-100 baud generator.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 100;
    localparam int unsigned DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_wiz_if.sv
// Receiver output bundle: byte, strobes and busy flag towards the packet logic.
interface uart_rx_wiz_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 framing_err_out;
    logic                 busy_out;

    modport master (
        output data_out,
        output valid_out,
        output framing_err_out,
        output busy_out
    );

    modport slave (
        input data_out,
        input valid_out,
        input framing_err_out,
        input busy_out
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);
    logic meta_q;
    logic sync_q;

    // Capture the async pin, then let any metastability settle for one more cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;
endmodule

// File: rtl/uart_rx_wiz.sv
// 8N1-style UART receiver: mid-bit sampling, one-cycle valid and framing-error strobes.
module uart_rx_wiz
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rx_in,
    uart_rx_wiz_if.master rx_if
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    // Reset value 1 so the line reads idle while and right after reset.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (rx_in),
        .q_out  (rx_s)
    );

    // Frame FSM with registered outputs; the counter restarts on every state entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BREAK: begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_if.data_out        = data_q;
    assign rx_if.valid_out       = valid_q;
    assign rx_if.framing_err_out = ferr_q;
    assign rx_if.busy_out        = busy_q;
endmodule
